// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM control unit: state sequencer, decoder, NZCV flags
//
// Purpose: sequences each instruction through fetch/decode/execute/memory/
// writeback as a Moore FSM, decodes the instruction word into datapath
// selects and enables, holds the NZCV flags and gates architectural writes
// on the instruction's condition.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   Instr      instruction register contents [31:12] (cond, op, funct, Rd)
//   ALUFlags   live ALU flags {N,Z,C,V}
//   PCWrite    PC enable            MemWrite   data memory write enable
//   RegWrite   register file enable IRWrite    instruction register enable
//   AdrSrc     address select (0 PC, 1 Result)
//   RegSrc     bit0: RA1=15, bit1: RA2=Rd
//   ALUSrcA    00 A reg, 01 PC
//   ALUSrcB    00 WriteData, 01 ExtImm, 10 constant 4
//   ResultSrc  00 ALUOut, 01 Data, 10 ALUResult
//   ImmSrc     extend mode (Instr[27:26])
//   ALUControl 000 ADD, 001 SUB, 010 AND, 011 ORR
module mc_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [2:0]   ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  state_t     state, next_state;
  logic [3:0] flags;
  logic       cond_ex;
  logic       cond_ex_r;

  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       rd_is_pc;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign imm_bit   = Instr[25];
  assign cmd       = Instr[24:21];
  assign s_bit     = Instr[20];
  assign rd_is_pc  = (Instr[15:12] == 4'hF);
  assign unused_rn = ^Instr[19:16];

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = flag_z;
      4'h1: cond_ex = ~flag_z;
      4'h2: cond_ex = flag_c;
      4'h3: cond_ex = ~flag_c;
      4'h4: cond_ex = flag_n;
      4'h5: cond_ex = ~flag_n;
      4'h6: cond_ex = flag_v;
      4'h7: cond_ex = ~flag_v;
      4'h8: cond_ex = flag_c & ~flag_z;
      4'h9: cond_ex = ~flag_c | flag_z;
      4'hA: cond_ex = (flag_n == flag_v);
      4'hB: cond_ex = (flag_n != flag_v);
      4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
      4'hD: cond_ex = flag_z | (flag_n != flag_v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic [2:0] alu_ctl;
  logic       no_write;
  logic       cv_update;

  always_comb begin
    alu_ctl   = 3'b000;
    no_write  = 1'b0;
    cv_update = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl = 3'b000; cv_update = 1'b1; end
      4'b0010: begin alu_ctl = 3'b001; cv_update = 1'b1; end
      4'b1010: begin alu_ctl = 3'b001; cv_update = 1'b1; no_write = 1'b1; end
      4'b0000: alu_ctl = 3'b010;
      4'b1100: alu_ctl = 3'b011;
      default: alu_ctl = 3'b000;
    endcase
  end

  logic in_exec;
  assign in_exec = (state == S_EXECR) || (state == S_EXECI);

  // Writeback uses the condition captured before this instruction's own
  // flag update, so a flag-setting instruction cannot veto its own write.
  logic alu_wb_en;
  logic mem_wb_en;
  assign alu_wb_en = cond_ex_r & ~no_write;
  assign mem_wb_en = cond_ex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      state <= next_state;
      if (in_exec) begin
        cond_ex_r <= cond_ex;
        if (s_bit && cond_ex) begin
          flags[3:2] <= ALUFlags[3:2];
          if (cv_update) flags[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = {op == 2'b01, op == 2'b10};
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = op;
    ALUControl = 3'b000;
    case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // PC+4 computed again here so R15 reads as PC+8.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   next_state = imm_bit ? S_EXECI : S_EXECR;
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = mem_wb_en;
        PCWrite    = mem_wb_en & rd_is_pc;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        MemWrite   = cond_ex;
        next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUControl = alu_ctl;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctl;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = alu_wb_en;
        PCWrite    = alu_wb_en & rd_is_pc;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Control unit for the multicycle ARM datapath. It sequences every instruction through fetch, decode, execute, memory and writeback with a Moore state machine. It decodes the instruction word to produce all datapath select and enable lines. It holds the NZCV condition flags and suppresses architectural writes when an instruction's condition fails.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; 0 forces state and flags to reset values immediately
- Instr  input  [31:12]  instruction register contents (cond, op, funct, Rd)
- ALUFlags  input  [3:0]  live ALU flags {N,Z,C,V}
- PCWrite  output  1  PC register enable
- MemWrite  output  1  data memory write enable
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- RegSrc  output  [1:0]  bit0 selects RA1 = 15; bit1 selects RA2 = Instr[15:12]
- ALUSrcA  output  [1:0]  00 = A register, 01 = PC; 1x is not driven
- ALUSrcB  output  [1:0]  00 = WriteData register, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  [1:0]  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  output  [1:0]  extend mode; always equals Instr[27:26]
- ALUControl  output  [2:0]  000 ADD, 001 SUB, 010 AND, 011 ORR

## Operation
Field names: Op = Instr[27:26], I = Instr[25], cmd = Instr[24:21], S = Instr[20], L = Instr[20], Rd = Instr[15:12], cond = Instr[31:28].

States and transitions:
- FETCH -> DECODE.
- DECODE: Op=00, I=0 -> EXECR. Op=00, I=1 -> EXECI. Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> FETCH (undefined op is a no-op).
- MEMADR: L=1 -> MEMRD; L=0 -> MEMWR.
- MEMRD -> MEMWB -> FETCH.
- MEMWR -> FETCH.
- EXECR and EXECI -> ALUWB -> FETCH.
- BRANCH -> FETCH.

Moore outputs per state. Any output not listed is 0; ALUControl defaults to 000.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. PCWrite=1 unconditionally.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. This supplies PC+8 as R15.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=CondEx.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUControl from cmd.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALUControl from cmd.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx.
- In MEMWB and ALUWB, PCWrite is also 1 when Rd=15 and the register write actually occurs.

Datapath decode:
- cmd 0100 ADD -> 000.
- cmd 0010 SUB -> 001.
- cmd 1010 CMP -> 001, with NoWrite=1.
- cmd 0000 AND -> 010.
- cmd 1100 ORR -> 011.
- Any other cmd -> 000.

Flag and condition rules:
- Flags update in EXECR/EXECI only, and only if S=1 and CondEx=1.
- N and Z update from ALUFlags[3:2] for every cmd.
- C and V update from ALUFlags[1:0] only for ADD, SUB and CMP.
- Register and memory decode: RegSrc[0] = (Op==10); RegSrc[1] = (Op==01).
- CondEx is combinational from cond and the flags register, using the full ARM table (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL). cond=1111 evaluates as false.

## Timing
- Reset (reset=0): state = FETCH and flags = 0000, asynchronously. Outputs immediately show FETCH values (IRWrite=1, PCWrite=1, ResultSrc=10), and the datapath registers are also held in reset.
- First edge after reset deasserts performs the first fetch.
- Cycle counts per instruction: LDR 5, STR 4, data-processing 4, B 3, undefined op 2.
- A failed condition still walks the full state path. Only the RegWrite, MemWrite, branch/R15 PCWrite and flag writes are suppressed; the FETCH PC+4 write is unaffected.
- Flags written in EXECx are visible to CondEx from the next cycle. CondEx for the same instruction's writeback uses the flags as they were before the update. Implement this by registering CondEx at the end of EXECx; a flag-setting instruction must not be able to suppress its own write.
- Reset asserted mid-instruction aborts the instruction with no further writes.

## Test plan
- Reset release: hold reset=0 for 2 cycles -> FETCH outputs present. After 1 edge the state is DECODE with IRWrite=0, PCWrite=0.
- ADD R1,R2,#5 (0xE2821005): 4 cycles. EXECI shows ALUSrcB=01, ALUControl=000. ALUWB shows RegWrite=1, ResultSrc=00. Flags stay 0000.
- SUBS with ALUFlags=0100 in EXECR, then BEQ (0x0A000002) -> BRANCH state asserts PCWrite=1. Repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
- LDR (0xE5912004) walks FETCH, DECODE, MEMADR, MEMRD, MEMWB with AdrSrc=1 in MEMRD and ResultSrc=01 with RegWrite=1 in MEMWB. STR (0xE5812004) asserts MemWrite=1 in MEMWR only.
- CMP (0xE1510002) -> RegWrite=0 in ALUWB and all flags update. ADD with Rd=15 -> PCWrite=1 and RegWrite=1 in ALUWB.
- Drive reset=0 during MEMRD -> state is FETCH within the same cycle, flags = 0000, and no RegWrite pulse occurs.
